master_bridge_r_channel_ctrl: RTL
=================================

Name: master_bridge_r_channel_ctrl

Overview:
- Read-side sequencer between the R-channel async FIFO pair (info FIFO and data FIFO) and the AXI4 R channel of the master bridge. Runs in the FIFO read-clock domain.
- Pops one info entry per burst and decodes ID, RESP and LEN from it. Then pops LEN+1 data beats and drives them through a registered AXI R output stage with RLAST on the final beat.
- Uses separate empty flags for the info and data FIFOs. This prevents deadlock when the info FIFO is drained before the data FIFO.

Parameters:
- BEAT_SIZE, 1024: R data beat width in bits.
- R_CH_INFO_WIDTH, 30: info FIFO entry width in bits.
- ID_WIDTH, 10: AXI RID width in bits.
- LEN_WIDTH, 8: AXI burst-length field width in bits (beats minus 1).

Ports:
- i_clk, input, 1: read-domain clock.
- i_n_rst, input, 1: reset, asynchronous, active-low.
- i_info_empty, input, 1: info FIFO empty flag.
- i_info, input, R_CH_INFO_WIDTH: info FIFO head entry. Valid while i_info_empty=0.
- o_info_inc, output, 1: info FIFO pop strobe.
- i_data_empty, input, 1: data FIFO empty flag.
- i_data, input, BEAT_SIZE: data FIFO head beat. Valid while i_data_empty=0.
- o_data_inc, output, 1: data FIFO pop strobe.
- o_rvalid, output, 1: AXI RVALID.
- i_rready, input, 1: AXI RREADY.
- o_rdata, output, BEAT_SIZE: AXI RDATA.
- o_rid, output, ID_WIDTH: AXI RID.
- o_rresp, output, 2: AXI RRESP.
- o_rlast, output, 1: AXI RLAST.
- o_busy, output, 1: a burst is in progress.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_n_rst is asynchronous and active-low.
- Reset values:
  - State is IDLE.
  - o_rvalid, o_rlast, o_busy, o_info_inc and o_data_inc are 0.
  - o_rdata, o_rid, o_rresp, the beat counter and the latched fields are all 0.
- Reset mid-burst: the burst is abandoned immediately. No pop strobes occur during reset. FIFO contents are not touched by this block.
- Info field layout: [LEN_WIDTH-1:0] is LEN; [LEN_WIDTH+1:LEN_WIDTH] is RESP; the next ID_WIDTH bits are ID. Remaining upper bits are reserved and ignored.
- Both FIFOs present their head entry combinationally. A pop strobe that is high at a clock edge advances the FIFO by one entry.
- Pop strobes are combinational:
  - o_info_inc = (state==IDLE) & ~i_info_empty.
  - o_data_inc = load, where load = (state==BURST) & ~i_data_empty & (~o_rvalid | i_rready).
- FSM states and transitions:
  - IDLE: if ~i_info_empty, latch ID/RESP/LEN, clear beat_cnt, and go to BURST. Otherwise stay in IDLE.
  - BURST: on each load, beat_cnt increments. On a load with beat_cnt==LEN, go to IDLE.
- beat_cnt is LEN_WIDTH bits wide. It never wraps, because the exit condition is beat_cnt==LEN.
- o_busy = (state==BURST).
- Output register:
  - On load: o_rdata<=i_data, o_rid<=latched ID, o_rresp<=latched RESP, o_rlast<=(beat_cnt==LEN), o_rvalid<=1.
  - If there is no load and o_rvalid & i_rready: o_rvalid<=0 and o_rlast<=0.
  - While o_rvalid & ~i_rready: all R outputs hold stable (AXI rule). No data pop occurs.
- Latency:
  - Info at the FIFO head with IDLE state gives a pop on the same cycle and BURST on the next edge.
  - The first data pop happens in the first BURST cycle. o_rvalid rises one edge later.
  - Minimum idle-to-RVALID latency is therefore 2 cycles.
- Throughput:
  - One beat per cycle is sustained when i_rready=1 and data is available.
  - There is one bubble cycle between bursts (the IDLE cycle).
  - The last beat may still be held in the output register during IDLE; the next info pop is allowed regardless.
- Boundary conditions:
  - LEN=0 gives a single beat with o_rlast=1.
  - Data FIFO empty mid-burst: o_rvalid deasserts after the current beat is accepted, then the burst resumes when data returns. Beat order and RLAST position are unaffected.
  - Info FIFO non-empty during BURST is ignored until the FSM returns to IDLE.
  - Simultaneous accept and load: o_rvalid stays 1 and the new beat replaces the old one in the same edge.

Decomposition:
- Shared package master_bridge_pkg holds:
  - info field offset constants (LEN_LSB, RESP_LSB, ID_LSB);
  - AXI RRESP encodings (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11);
  - FSM state localparams (IDLE=1'b0, BURST=1'b1).
- No sub-module. The output register stage is inline. The block is instantiated alongside master_bridge_r_channel_async_fifo in the master-bridge R path.

Test Plan:
- Reset with both FIFOs non-empty -> no pops, o_rvalid=0. After release, o_info_inc pulses at cycle 1 and o_rvalid=1 at cycle 3.
- Info {ID=10'h05, RESP=OKAY, LEN=3}, 4 data beats D0..D3, i_rready=1 -> 4 consecutive beats D0..D3 with RID=5, o_rlast=1 only on D3, then o_busy=0.
- LEN=0, ID=10'h3FF, RESP=SLVERR -> one beat with o_rlast=1, o_rresp=2'b10, o_rid=10'h3FF.
- LEN=7 with i_rready toggling 1,0,0,1,... -> o_rdata/o_rid/o_rlast stable while stalled. o_data_inc is never high while o_rvalid=1 and i_rready=0. All 8 beats arrive in order.
- Data FIFO empty after 2 of 4 beats for 5 cycles -> o_rvalid drops, o_busy stays 1. Beats 3–4 follow, with o_rlast on beat 4.
- Two queued bursts (LEN=1 ID=1, LEN=2 ID=2) -> 5 beats total, one-cycle gap between bursts, RLAST on beats 2 and 5. i_n_rst asserted mid-second-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/master_bridge_pkg.sv
// Shared constants for the master bridge: info FIFO entry layout, AXI RRESP codes
// and the R-channel sequencer states.
package master_bridge_pkg;

  // Info entry layout: {reserved, ID, RESP, LEN}; offsets match LEN_WIDTH=8, ID_WIDTH=10.
  localparam int LEN_LSB  = 0;
  localparam int RESP_LSB = 8;
  localparam int ID_LSB   = 10;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/master_bridge_r_channel_ctrl.sv
// Read-side sequencer: pops one info entry per burst, then LEN+1 data beats into a
// registered AXI R output stage with RLAST on the final beat.
module master_bridge_r_channel_ctrl
  import master_bridge_pkg::*;
#(
  parameter int BEAT_SIZE       = 1024,
  parameter int R_CH_INFO_WIDTH = 30,
  parameter int ID_WIDTH        = 10,
  parameter int LEN_WIDTH       = 8
) (
  input  logic                       i_clk,
  input  logic                       i_n_rst,
  input  logic                       i_info_empty,
  input  logic [R_CH_INFO_WIDTH-1:0] i_info,
  output logic                       o_info_inc,
  input  logic                       i_data_empty,
  input  logic [BEAT_SIZE-1:0]       i_data,
  output logic                       o_data_inc,
  output logic                       o_rvalid,
  input  logic                       i_rready,
  output logic [BEAT_SIZE-1:0]       o_rdata,
  output logic [ID_WIDTH-1:0]        o_rid,
  output logic [1:0]                 o_rresp,
  output logic                       o_rlast,
  output logic                       o_busy
);

  state_t               state;
  logic [ID_WIDTH-1:0]  lat_id;
  logic [1:0]           lat_resp;
  logic [LEN_WIDTH-1:0] lat_len;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic                 load;
  logic                 last_beat;
  logic                 info_unused;

  assign info_unused = ^i_info[R_CH_INFO_WIDTH-1:ID_LSB+ID_WIDTH];

  // A new beat may enter the output register when it is empty or being drained this cycle.
  assign load      = (state == BURST) && !i_data_empty && (!o_rvalid || i_rready);
  assign last_beat = (beat_cnt == lat_len);

  // The pop strobe is gated by reset so the FIFO never advances while held in reset.
  assign o_info_inc = i_n_rst && (state == IDLE) && !i_info_empty;
  assign o_data_inc = load;
  assign o_busy     = (state == BURST);

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      state    <= IDLE;
      lat_id   <= '0;
      lat_resp <= OKAY;
      lat_len  <= '0;
      beat_cnt <= '0;
      o_rvalid <= 1'b0;
      o_rlast  <= 1'b0;
      o_rdata  <= '0;
      o_rid    <= '0;
      o_rresp  <= OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (!i_info_empty) begin
            lat_id   <= i_info[ID_LSB +: ID_WIDTH];
            lat_resp <= i_info[RESP_LSB +: 2];
            lat_len  <= i_info[LEN_LSB +: LEN_WIDTH];
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (load) begin
            if (last_beat) state <= IDLE;
            else           beat_cnt <= beat_cnt + LEN_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // R output stage: a load overwrites even while the previous beat is being accepted.
      if (load) begin
        o_rdata  <= i_data;
        o_rid    <= lat_id;
        o_rresp  <= lat_resp;
        o_rlast  <= last_beat;
        o_rvalid <= 1'b1;
      end else if (o_rvalid && i_rready) begin
        o_rvalid <= 1'b0;
        o_rlast  <= 1'b0;
      end
    end
  end

endmodule
